traffic_sched: RTL and testbench

- Single-clock run controller and injection arbiter for the NoC traffic bench.
- Sequences a run through five phases: idle, warm-up after reset, send window, cool-down drain, done.
- During the send window it grants injection to NUM_NODES requesting nodes, round-robin, one grant at a time, rate-limited by a minimum gap.
- Replaces free-running send/cool-down delays with a synthesizable, cycle-exact sequencer.

---
 rtl/traffic_sched.sv | 112 +++++++++++
 tb/tb_traffic_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_sched.sv
// Run sequencer and round-robin injection arbiter for the NoC traffic bench.
// Phases: idle, warm-up, send window, cool-down drain, done.
module traffic_sched #(
   parameter int NUM_NODES       = 9,
   parameter int WARMUP_CYCLES   = 30,
   parameter int SIM_CYCLES      = 10000,
   parameter int COOLDOWN_CYCLES = 10000,
   parameter int INJ_GAP         = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_NODES-1:0] req,
   output logic [NUM_NODES-1:0] grant,
   output logic                 send,
   output logic [2:0]           phase,
   output logic                 done,
   output logic [31:0]          grant_total
);

   localparam int PW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

   typedef enum logic [2:0] {
      st_idle = 3'd0,
      st_warm = 3'd1,
      st_send = 3'd2,
      st_drain = 3'd3,
      st_done = 3'd4
   } phase_e;

   phase_e          state;
   phase_e          nxt;
   logic [31:0]     cnt;
   logic [31:0]     cnt_nxt;
   logic [31:0]     gap;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [PW-1:0]   idx;
   logic [PW-1:0]   ptr_nxt;
   logic            hit;
   logic            issue;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= st_idle;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt + 32'd1;
      unique case (state)
         st_idle: if (start) nxt = st_warm;
         st_warm:
            if (cnt == 32'(WARMUP_CYCLES - 1)) nxt = st_send;
         st_send:
            if (cnt == 32'(SIM_CYCLES - 1)) nxt = st_drain;
         st_drain:
            if (cnt == 32'(COOLDOWN_CYCLES - 1)) nxt = st_done;
         st_done: nxt = st_done;
         default: nxt = st_idle;
      endcase
      if (nxt != state || nxt == st_idle || nxt == st_done)
         cnt_nxt = '0;
   end

   // Grant decision belongs to the cycle being entered, hence nxt.
   always_comb begin
      hit = 1'b0;
      win = ptr;
      idx = ptr;
      for (int i = 0; i < NUM_NODES; i++) begin
         idx = PW'((int'(ptr) + i) % NUM_NODES);
         if (!hit && req[idx]) begin
            hit = 1'b1;
            win = idx;
         end
      end
      ptr_nxt = PW'((int'(win) + 1) % NUM_NODES);
      issue   = hit && (gap == 32'd0) && (nxt == st_send);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant       <= '0;
         send        <= 1'b0;
         done        <= 1'b0;
         phase       <= 3'd0;
         grant_total <= '0;
         gap         <= '0;
         ptr         <= '0;
      end else begin
         send  <= (nxt == st_send);
         done  <= (nxt == st_done);
         phase <= nxt;
         if (issue) begin
            grant       <= NUM_NODES'(1) << win;
            grant_total <= grant_total + 32'd1;
            gap         <= 32'(INJ_GAP - 1);
            ptr         <= ptr_nxt;
         end else begin
            grant <= '0;
            if (gap != 32'd0) gap <= gap - 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_traffic_sched.sv
// Bench for traffic_sched: directed runs plus random req against
// a timeline-based model of phases, gap and round-robin order.
module tb_traffic_sched;

   localparam int N = 4;
   localparam int W = 3;
   localparam int S = 12;
   localparam int C = 4;
   localparam int G = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [N-1:0]  req;
   logic [N-1:0]  grant;
   logic          send;
   logic [2:0]    phase;
   logic          done;
   logic [31:0]   grant_total;

   int n_vec = 0;
   int n_err = 0;

   bit          running;
   int          t;
   int          ptr_m;
   int          edge_n;
   int          last_g;
   int          total_m;
   logic [N-1:0] exp_g;

   always #5 clk = ~clk;

   traffic_sched #(
      .NUM_NODES(N),
      .WARMUP_CYCLES(W),
      .SIM_CYCLES(S),
      .COOLDOWN_CYCLES(C),
      .INJ_GAP(G)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .req(req),
      .grant(grant),
      .send(send),
      .phase(phase),
      .done(done),
      .grant_total(grant_total)
   );

   function automatic int phase_of(bit run, int tt);
      if (!run) return 0;
      if (tt <= W) return 1;
      if (tt <= W + S) return 2;
      if (tt <= W + S + C) return 3;
      return 4;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      running = 1'b0;
      t       = 0;
      ptr_m   = 0;
      last_g  = -1000;
      total_m = 0;
      exp_g   = '0;
   endtask

   task automatic check_all();
      int p;
      p = phase_of(running, t);
      chk("phase", 32'(phase), 32'(p));
      chk("send", 32'(send), 32'(p == 2));
      chk("done", 32'(done), 32'(p == 4));
      chk("grant", 32'(grant), 32'(exp_g));
      chk("grant_total", grant_total, 32'(total_m));
      n_vec++;
      assert ($onehot0(grant)) else begin
         n_err++;
         $error("FAIL onehot: got %b want at most one bit", grant);
      end
   endtask

   task automatic step(logic s, logic [N-1:0] r);
      start = s;
      req   = r;
      @(posedge clk);
      edge_n++;
      if (!reset) begin
         model_reset();
      end else begin
         if (running) t++;
         else if (s) begin
            running = 1'b1;
            t       = 1;
         end
         exp_g = '0;
         if (phase_of(running, t) == 2 && edge_n - last_g >= G) begin
            for (int i = 0; i < N; i++) begin
               int k;
               k = (ptr_m + i) % N;
               if (r[k]) begin
                  exp_g[k] = 1'b1;
                  ptr_m    = (k + 1) % N;
                  last_g   = edge_n;
                  total_m++;
                  break;
               end
            end
         end
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step(1'b0, '0);
      step(1'b0, '0);
      reset = 1'b1;
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      req    = '0;
      edge_n = 0;
      model_reset();

      repeat (3) step(1'b0, '0);
      reset = 1'b1;
      repeat (6) step(1'b0, 4'hF);

      // full run, all nodes requesting, stray start pulses
      step(1'b1, 4'hF);
      repeat (W + S + C + 3) step(1'($urandom_range(0, 1)), 4'hF);
      chk("total_run_all", grant_total, 32'd6);

      // single requester, then switch to nodes 3 and 0
      do_reset();
      step(1'b1, 4'b0100);
      repeat (W + 6) step(1'b0, 4'b0100);
      repeat (S) step(1'b0, 4'b1001);
      chk("total_switch", grant_total, 32'd6);

      // asynchronous reset in SEND cycle 6
      do_reset();
      step(1'b1, 4'($urandom));
      repeat (W + 5) step(1'b0, 4'($urandom));
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all();
      step(1'b0, 4'hF);
      reset = 1'b1;
      step(1'b1, 4'($urandom));
      repeat (W + S + C + 2) step(1'b0, 4'($urandom));

      // requests only outside the send window
      do_reset();
      for (int e = 0; e < W + S + C + 3; e++) begin
         int np;
         np = phase_of(1'b1, e + 1);
         step(e == 0, (np == 1 || np == 3) ? 4'hF : 4'h0);
      end
      chk("total_no_send", grant_total, 32'd0);

      // random runs
      repeat (3) begin
         do_reset();
         repeat (2) step(1'b0, 4'($urandom));
         step(1'b1, 4'($urandom));
         repeat (W + S + C + 3)
            step(1'($urandom_range(0, 1)), 4'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
